instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the main control decoder: packs an operation selector plus operand fields into
//  32-bit MIPS instruction words using the same opcode table. Each word is written
//  sequentially into instruction memory from a base address.
//  Sits between the bench/boot program source and instruction memory; loads programs before the CPU runs.
// PARAMETERS
//  ADDR_WIDTH  8  word-address width of instruction memory; capacity = 2**ADDR_WIDTH words
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           asynchronous, active-high reset
//  start       in   1           begin load session (honoured in IDLE, DONE, ERROR only)
//  base_addr   in   ADDR_WIDTH  first word address, sampled on accepted start
//  in_valid    in   1           operand bundle valid
//  in_ready    out  1           block can accept a bundle
//  in_op       in   4           0 RTYPE,1 J,2 JAL,3 ADDI,4 SLTI,5 ANDI,6 ORI,7 XORI,8 LUI,9 LW,10 SW,11 BEQ,12 BNE
//  in_rs/in_rt/in_rd/in_shamt  in  5 each  register/shift fields
//  in_funct    in   6           R-type funct
//  in_imm      in   16          I-type immediate
//  in_target   in   26          J/JAL target
//  in_last     in   1           bundle is final word of program
//  mem_we      out  1           instruction-memory write strobe (one cycle per word)
//  mem_addr    out  ADDR_WIDTH  write word address
//  mem_wdata   out  32          encoded instruction
//  busy        out  1           high in LOAD/WRITE
//  done        out  1           high in DONE
//  error       out  1           high in ERROR
//  word_count  out  ADDR_WIDTH+1 words written this session
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; base/count registers 0. Reset mid-WRITE drops mem_we immediately.
//  - FSM: IDLE -start-> LOAD; LOAD -accept legal-> WRITE; LOAD -accept illegal (13..15)-> ERROR (no write);
//    WRITE -> DONE if captured in_last; else ERROR if word_count becomes 2**ADDR_WIDTH; else LOAD.
//    DONE/ERROR -start-> LOAD (count cleared, error/done cleared, new base sampled). start elsewhere ignored.
//  - in_ready = 1 only in LOAD (registered). Accept = in_valid & in_ready. One word per 2 cycles max.
//  - Latency: bundle accepted at edge N -> mem_we=1 with addr/data during cycle N+1..N+2 (exactly one cycle).
//  - Encoding (registered at accept):
//    RTYPE {6'b000000,rs,rt,rd,shamt,funct}; J {6'b000010,target}; JAL {6'b000011,target};
//    I-type {opc,rs,rt,imm}: ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110,
//    LUI 001111 (rs field forced 0), LW 100011, SW 101011, BEQ 000100, BNE 000101.
//  - mem_addr = (base + word_count) mod 2**ADDR_WIDTH; wraps silently past all-ones.
//  - word_count increments at end of each WRITE cycle; holds in DONE/ERROR.
//  - mem_wdata holds last written value outside WRITE; mem_we 0 outside WRITE.
//  - Ignored inputs: fields not used by the selected format have no effect on mem_wdata.
// TESTING
//  1. start base=0x10; ADDI rs=1 rt=2 imm=0x0005 last=1 -> one mem_we, addr 0x10, data 0x20220005; done=1, count=1.
//  2. RTYPE rs=1 rt=2 rd=3 funct=0x20 -> 0x00221820; J tgt=0x40 -> 0x08000040; JAL tgt=0x3FFFFFF -> 0x0FFFFFFF.
//  3. LUI rs=7 rt=4 imm=0x1234 -> 0x3C041234; SW rs=29 rt=31 imm=0xFFFC -> 0xAFBFFFFC; addrs consecutive.
//  4. in_op=14 -> no mem_we, error=1, in_ready=0; later start -> error=0, LOAD, count=0.
//  5. ADDR_WIDTH=2, base=3, 4 words no last -> addrs 3,0,1,2; then error=1, count=4.
//  6. in_valid held high continuously -> in_ready toggles, exactly one write per 2 cycles; reset asserted during WRITE -> mem_we=0 at once, all outputs 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs operation selector + operand fields into
// 32-bit MIPS words and writes them sequentially into instruction memory.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   start, base_addr    begin a load session at base_addr (IDLE/DONE/ERROR only)
//   in_valid, in_ready  operand bundle handshake (ready only in LOAD)
//   in_op .. in_last    operation selector, operand fields, final-word flag
//   mem_we/addr/wdata   one-cycle instruction-memory write per word
//   busy, done, error   session status
//   word_count          words written in the current session
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_J     = 4'd1;
    localparam logic [3:0] OP_JAL   = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_ANDI  = 4'd5;
    localparam logic [3:0] OP_ORI   = 4'd6;
    localparam logic [3:0] OP_XORI  = 4'd7;
    localparam logic [3:0] OP_LUI   = 4'd8;
    localparam logic [3:0] OP_LW    = 4'd9;
    localparam logic [3:0] OP_SW    = 4'd10;
    localparam logic [3:0] OP_BEQ   = 4'd11;
    localparam logic [3:0] OP_BNE   = 4'd12;

    // Memory is full once the count reaches 2**ADDR_WIDTH words.
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_inc;
    logic [31:0]           wdata;
    logic                  last;
    logic                  accept;
    logic                  legal;
    logic [31:0]           encoded;
    logic                  session_start;

    // Opcode table: the inverse of the main control decoder.
    always_comb begin
        legal   = 1'b1;
        encoded = 32'h0;
        case (in_op)
            OP_RTYPE: encoded = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            OP_J:     encoded = {6'b000010, in_target};
            OP_JAL:   encoded = {6'b000011, in_target};
            OP_ADDI:  encoded = {6'b001000, in_rs, in_rt, in_imm};
            OP_SLTI:  encoded = {6'b001010, in_rs, in_rt, in_imm};
            OP_ANDI:  encoded = {6'b001100, in_rs, in_rt, in_imm};
            OP_ORI:   encoded = {6'b001101, in_rs, in_rt, in_imm};
            OP_XORI:  encoded = {6'b001110, in_rs, in_rt, in_imm};
            // LUI has no source register; the field is architecturally zero.
            OP_LUI:   encoded = {6'b001111, 5'd0, in_rt, in_imm};
            OP_LW:    encoded = {6'b100011, in_rs, in_rt, in_imm};
            OP_SW:    encoded = {6'b101011, in_rs, in_rt, in_imm};
            OP_BEQ:   encoded = {6'b000100, in_rs, in_rt, in_imm};
            OP_BNE:   encoded = {6'b000101, in_rs, in_rt, in_imm};
            default:  legal   = 1'b0;
        endcase
    end

    assign in_ready  = (state == LOAD);
    assign accept    = in_valid & in_ready;
    assign count_inc = count + (ADDR_WIDTH + 1)'(1);

    // start is honoured only while no session is in progress.
    assign session_start = start &
        ((state == IDLE) | (state == DONE) | (state == ERROR));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (accept) state_next = legal ? WRITE : ERROR;
            end
            WRITE: begin
                if (last) begin
                    state_next = DONE;
                end else if (count_inc == CAPACITY) begin
                    state_next = ERROR;
                end else begin
                    state_next = LOAD;
                end
            end
            DONE, ERROR: begin
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base  <= '0;
            count <= '0;
            wdata <= '0;
            last  <= 1'b0;
        end else begin
            if (session_start) begin
                base  <= base_addr;
                count <= '0;
            end
            // An illegal selector leaves the last written word untouched.
            if (accept && legal) begin
                wdata <= encoded;
                last  <= in_last;
            end
            if (state == WRITE) begin
                count <= count_inc;
            end
        end
    end

    // Address wraps silently modulo the memory size.
    assign mem_addr   = base + count[ADDR_WIDTH-1:0];
    assign mem_wdata  = wdata;
    assign mem_we     = (state == WRITE);
    assign busy       = (state == LOAD) | (state == WRITE);
    assign done       = (state == DONE);
    assign error      = (state == ERROR);
    assign word_count = count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, addressing,
// illegal selectors, capacity overflow, back-to-back handshake and reset.
module tb_instr_encoder_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // Main instance, ADDR_WIDTH = 8
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, error;
    logic [8:0]  word_count;

    // Small instance, ADDR_WIDTH = 2
    logic        start2 = 1'b0;
    logic [1:0]  base2 = '0;
    logic        valid2 = 1'b0;
    logic        ready2;
    logic [15:0] imm2 = '0;
    logic        we2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic        busy2, done2, error2;
    logic [2:0]  count2;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    instr_encoder_loader #(.ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .base_addr(base2),
        .in_valid(valid2), .in_ready(ready2), .in_op(4'd3),
        .in_rs(5'd1), .in_rt(5'd2), .in_rd(5'd0), .in_shamt(5'd0),
        .in_funct(6'd0), .in_imm(imm2), .in_target(26'd0),
        .in_last(1'b0), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .busy(busy2), .done(done2), .error(error2),
        .word_count(count2)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic begin_session(input logic [7:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Present one bundle, then check the single write cycle that follows.
    task automatic push(input string tag, input logic [3:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic lst,
                        input logic [7:0] exp_addr, input logic [31:0] exp_data);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; in_last = lst;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check({tag, "_we"},   64'(mem_we),    64'(1));
        check({tag, "_addr"}, 64'(mem_addr),  64'(exp_addr));
        check({tag, "_data"}, 64'(mem_wdata), 64'(exp_data));
        @(posedge clock);
        #1;
        check({tag, "_we_off"}, 64'(mem_we), 64'(0));
    endtask

    initial begin
        #12;
        check("rst_we",    64'(mem_we),     64'(0));
        check("rst_ready", 64'(in_ready),   64'(0));
        check("rst_addr",  64'(mem_addr),   64'(0));
        check("rst_data",  64'(mem_wdata),  64'(0));
        check("rst_count", 64'(word_count), 64'(0));
        check("rst_flags", 64'({busy, done, error}), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single ADDI word
        begin_session(8'h10);
        check("s1_busy", 64'(busy), 64'(1));
        push("addi", 4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0,
             1'b1, 8'h10, 32'h2022_0005);
        check("s1_done",  64'(done),       64'(1));
        check("s1_count", 64'(word_count), 64'(1));
        check("s1_busy0", 64'(busy),       64'(0));

        // Multi-word program, with junk in unused fields
        begin_session(8'h20);
        push("rtype", 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF,
             26'h3FF_FFFF, 1'b0, 8'h20, 32'h0022_1820);
        push("j", 4'd1, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF,
             26'h000_0040, 1'b0, 8'h21, 32'h0800_0040);
        push("jal", 4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0,
             26'h3FF_FFFF, 1'b0, 8'h22, 32'h0FFF_FFFF);
        push("lui", 4'd8, 5'd7, 5'd4, 5'd9, 5'd9, 6'h3F, 16'h1234,
             26'h3FF_FFFF, 1'b0, 8'h23, 32'h3C04_1234);
        push("sw", 4'd10, 5'd29, 5'd31, 5'd0, 5'd0, 6'd0, 16'hFFFC,
             26'd0, 1'b1, 8'h24, 32'hAFBF_FFFC);
        check("s2_done",  64'(done),       64'(1));
        check("s2_count", 64'(word_count), 64'(5));
        check("s2_hold",  64'(mem_wdata),  64'(32'hAFBF_FFFC));

        // Illegal selector
        begin_session(8'h00);
        in_op = 4'd14;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("ill_we",    64'(mem_we),    64'(0));
        check("ill_error", 64'(error),     64'(1));
        check("ill_ready", 64'(in_ready),  64'(0));
        check("ill_hold",  64'(mem_wdata), 64'(32'hAFBF_FFFC));
        @(posedge clock);
        #1;
        check("ill_stay", 64'(error), 64'(1));
        begin_session(8'h00);
        check("rest_error", 64'(error),      64'(0));
        check("rest_ready", 64'(in_ready),   64'(1));
        check("rest_count", 64'(word_count), 64'(0));

        // in_valid held high: one write every two cycles
        in_op = 4'd3; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h0007;
        in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("bb_we%0d", i), 64'(mem_we),
                  64'((i % 2) == 0));
            check($sformatf("bb_rdy%0d", i), 64'(in_ready),
                  64'((i % 2) == 1));
            if ((i % 2) == 0)
                check($sformatf("bb_addr%0d", i), 64'(mem_addr),
                      64'(i / 2));
        end
        check("bb_count", 64'(word_count), 64'(3));
        @(posedge clock);
        #1;
        check("bb_we_pre", 64'(mem_we), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        in_valid = 1'b0;
        check("ar_we",    64'(mem_we),     64'(0));
        check("ar_ready", 64'(in_ready),   64'(0));
        check("ar_addr",  64'(mem_addr),   64'(0));
        check("ar_data",  64'(mem_wdata),  64'(0));
        check("ar_count", 64'(word_count), 64'(0));
        check("ar_flags", 64'({busy, done, error}), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Capacity overflow with wrap on the 4-word instance
        start2 = 1'b1;
        base2  = 2'd3;
        @(posedge clock);
        #1;
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w_rdy%0d", k), 64'(ready2), 64'(1));
            imm2   = 16'(k);
            valid2 = 1'b1;
            @(posedge clock);
            #1;
            valid2 = 1'b0;
            check($sformatf("w_we%0d", k), 64'(we2), 64'(1));
            check($sformatf("w_addr%0d", k), 64'(addr2),
                  64'((3 + k) % 4));
            check($sformatf("w_data%0d", k), 64'(wdata2),
                  64'(32'h2022_0000 | k));
            @(posedge clock);
            #1;
        end
        check("w_error", 64'(error2), 64'(1));
        check("w_count", 64'(count2), 64'(4));
        check("w_we_off", 64'(we2), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
